// File: rtl/cla_pipe_adder.sv
// Pipelined carry look-ahead adder/subtractor.
//
// The operand is cut into NG = WIDTH/BLOCK groups of BLOCK bits. Stage k
// resolves group k-1 with a flat look-ahead carry network and registers the
// group carry-out for the next stage, so latency is NG cycles and throughput
// is one operation per cycle. All stages advance together under a single
// valid/ready handshake; a stalled output freezes the whole pipe.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   input handshake (in_ready = global advance)
//   a, b, cin, sub      operands; sub=1 computes a + ~b + 1 and ignores cin
//   out_valid/out_ready output handshake
//   sum, cout, ovf      result mod 2^WIDTH, MSB carry-out (1 = no borrow on
//                       sub), signed overflow
module cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4   // WIDTH must be a multiple of BLOCK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NG = WIDTH / BLOCK;

  // Carries c[0..BLOCK] of one group. Every c[i+1] is written as a
  // sum of products of G/P terms and c0 directly, so there is no ripple.
  function automatic logic [BLOCK:0] cla_carries(input logic [BLOCK-1:0] x,
                                                 input logic [BLOCK-1:0] y,
                                                 input logic             c0);
    logic [BLOCK-1:0] p, g;
    logic [BLOCK:0]   c;
    logic             t;
    p    = x ^ y;
    g    = x & y;
    c    = '0;
    c[0] = c0;
    for (int i = 0; i < BLOCK; i++) begin
      t = c0;
      for (int j = 0; j <= i; j++) t = t & p[j];
      c[i+1] = t;
      for (int j = 0; j <= i; j++) begin
        t = g[j];
        for (int k = j + 1; k <= i; k++) t = t & p[k];
        c[i+1] = c[i+1] | t;
      end
    end
    return c;
  endfunction

  // Per-stage state. a_q/b_q carry the operands forward (b already
  // inverted for subtract); sum_q holds the bits resolved so far.
  logic             vld_q [NG];
  logic [WIDTH-1:0] a_q   [NG];
  logic [WIDTH-1:0] b_q   [NG];
  logic [WIDTH-1:0] sum_q [NG];
  logic             c_q   [NG];
  logic             ovf_q;
  logic             advance;

  assign advance  = !vld_q[NG-1] || out_ready;
  assign in_ready = advance;

  for (genvar s = 0; s < NG; s++) begin : g_stg
    logic [WIDTH-1:0] a_in, b_in, s_in, s_nxt;
    logic             c_in, v_in;
    logic [BLOCK-1:0] pp;
    logic [BLOCK:0]   cc;

    if (s == 0) begin : g_first
      assign a_in = a;
      assign b_in = sub ? ~b : b;
      assign c_in = sub | cin;
      assign s_in = '0;
      assign v_in = in_valid;
    end else begin : g_next
      assign a_in = a_q[s-1];
      assign b_in = b_q[s-1];
      assign c_in = c_q[s-1];
      assign s_in = sum_q[s-1];
      assign v_in = vld_q[s-1];
    end

    assign pp = a_in[s*BLOCK +: BLOCK] ^ b_in[s*BLOCK +: BLOCK];
    assign cc = cla_carries(a_in[s*BLOCK +: BLOCK], b_in[s*BLOCK +: BLOCK], c_in);

    always_comb begin
      s_nxt                   = s_in;
      s_nxt[s*BLOCK +: BLOCK] = pp ^ cc[BLOCK-1:0];
    end

    // Bubbles shift like real entries; only the handshake gates motion.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q[s] <= 1'b0;
        a_q[s]   <= '0;
        b_q[s]   <= '0;
        sum_q[s] <= '0;
        c_q[s]   <= 1'b0;
      end else if (advance) begin
        vld_q[s] <= v_in;
        a_q[s]   <= a_in;
        b_q[s]   <= b_in;
        sum_q[s] <= s_nxt;
        c_q[s]   <= cc[BLOCK];
      end
    end

    if (s == NG - 1) begin : g_last
      // Carry into the MSB is cc[BLOCK-1] of the top group.
      always_ff @(posedge clk) begin
        if (rst)          ovf_q <= 1'b0;
        else if (advance) ovf_q <= cc[BLOCK] ^ cc[BLOCK-1];
      end
    end
  end

  // The last stage has nothing downstream to pass operands to.
  logic unused_ok;
  assign unused_ok = ^{a_q[NG-1], b_q[NG-1]};

  assign out_valid = vld_q[NG-1];
  assign sum       = sum_q[NG-1];
  assign cout      = c_q[NG-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
module tb_cla_pipe_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // 16-bit, 4 stages
  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [15:0] a16, b16, sum16;
  logic        cin16, sub16, cout16, ovf16;

  // 4-bit, single stage
  logic        in_valid4, in_ready4, out_valid4, out_ready4;
  logic [3:0]  a4, b4, sum4;
  logic        cin4, sub4, cout4, ovf4;

  cla_pipe_adder #(.WIDTH(16), .BLOCK(4)) u16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .cin(cin16), .sub(sub16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .sum(sum16), .cout(cout16), .ovf(ovf16));

  cla_pipe_adder #(.WIDTH(4), .BLOCK(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4), .sub(sub4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .cout(cout4), .ovf(ovf4));

  int tests = 0;
  int fails = 0;
  int nout  = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic, returns {cout, ovf, sum}.
  function automatic logic [17:0] model16(input logic [15:0] x, input logic [15:0] y,
                                          input logic ci, input logic s);
    int ux, uy, sx, sy, r, sr;
    logic co, ov;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (s) begin
      r  = ux - uy;
      co = (ux >= uy);
      sr = sx - sy;
    end else begin
      r  = ux + uy + int'(ci);
      co = (r > 65535);
      sr = sx + sy + int'(ci);
    end
    ov = (sr > 32767) || (sr < -32768);
    return {co, ov, r[15:0]};
  endfunction

  // Scoreboard + protocol checks on the 16-bit instance, every cycle.
  logic [17:0] q[$];
  logic [17:0] hold, e;
  logic        stall_prev = 1'b0;
  logic        prev_rst   = 1'b0;

  always @(negedge clk) begin
    if (prev_rst) begin
      chk("rst_out_valid", out_valid16, 0);
      chk("rst_outputs", {cout16, ovf16, sum16}, 0);
    end
    if (stall_prev && !prev_rst) begin
      chk("stall_valid", out_valid16, 1);
      chk("stall_hold", {cout16, ovf16, sum16}, hold);
    end
    chk("in_ready", in_ready16, !out_valid16 || out_ready16);
    if (out_valid16) chk("stale_result", q.size() == 0, 0);
    if (rst) begin
      q.delete();
    end else begin
      if (out_valid16 && out_ready16 && q.size() != 0) begin
        e = q.pop_front();
        chk("stream_result", {cout16, ovf16, sum16}, e);
        nout++;
      end
      if (in_valid16 && in_ready16) q.push_back(model16(a16, b16, cin16, sub16));
    end
    stall_prev = out_valid16 && !out_ready16 && !rst;
    hold       = {cout16, ovf16, sum16};
    prev_rst   = rst;
  end

  task automatic run16(input string nm, input logic [15:0] x, input logic [15:0] y,
                       input logic ci, input logic s, input logic [17:0] exp);
    int n;
    a16 = x; b16 = y; cin16 = ci; sub16 = s; in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    n = 0;
    while (!out_valid16 && n < 20) begin @(posedge clk); #1; n++; end
    chk({nm, "_latency"}, n, 3);
    chk(nm, {cout16, ovf16, sum16}, {14'd0, exp});
    @(posedge clk); #1;
  endtask

  task automatic run4(input string nm, input logic [3:0] x, input logic [3:0] y,
                      input logic [5:0] exp);
    int n;
    a4 = x; b4 = y; cin4 = 1'b0; sub4 = 1'b0; in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    n = 0;
    while (!out_valid4 && n < 20) begin @(posedge clk); #1; n++; end
    chk({nm, "_latency"}, n, 0);
    chk(nm, {cout4, ovf4, sum4}, {26'd0, exp});
    @(posedge clk); #1;
  endtask

  // {a, b, cout, ovf, sum}
  logic [13:0] vec4 [6] = '{
    {4'd3, 4'd2,  1'b0, 1'b0, 4'd5},
    {4'd7, 4'd2,  1'b0, 1'b1, 4'd9},
    {4'd2, 4'd13, 1'b0, 1'b0, 4'd15},
    {4'd2, 4'd2,  1'b0, 1'b0, 4'd4},
    {4'd4, 4'd8,  1'b0, 1'b0, 4'd12},
    {4'd3, 4'd13, 1'b1, 1'b0, 4'd0}
  };

  initial begin
    int nout0, g;
    rst = 1'b1;
    in_valid16 = 1'b0; out_ready16 = 1'b1; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0;
    in_valid4  = 1'b0; out_ready4  = 1'b1; a4  = '0; b4  = '0; cin4  = 1'b0; sub4  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset_out_valid16", out_valid16, 0);
    chk("reset_in_ready16", in_ready16, 1);
    chk("reset_outputs16", {cout16, ovf16, sum16}, 0);
    chk("reset_out_valid4", out_valid4, 0);
    chk("reset_in_ready4", in_ready4, 1);

    // Pin the reference model to hand-computed values.
    chk("model_ffff", model16(16'hFFFF, 16'h0001, 1'b0, 1'b0), {1'b1, 1'b0, 16'h0000});
    chk("model_sub",  model16(16'h8000, 16'h0001, 1'b0, 1'b1), {1'b1, 1'b1, 16'h7FFF});
    chk("model_cin",  model16(16'h0005, 16'h0005, 1'b1, 1'b1), {1'b1, 1'b0, 16'h0000});

    for (int i = 0; i < 6; i++)
      run4($sformatf("w4_add%0d", i), vec4[i][13:10], vec4[i][9:6], vec4[i][5:0]);

    run16("ffff_plus_1",  16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h0000});
    run16("8000_minus_1", 16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF});
    run16("1_minus_2",    16'h0001, 16'h0002, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFF});
    run16("7fff_plus_1",  16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h8000});
    run16("cin_add",      16'h00FF, 16'h0000, 1'b1, 1'b0, {1'b0, 1'b0, 16'h0100});
    run16("cin_ignored",  16'h0005, 16'h0005, 1'b1, 1'b1, {1'b1, 1'b0, 16'h0000});

    // Streaming with back-pressure
    nout0 = nout;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          a16   = 16'($urandom_range(0, 65535));
          b16   = 16'($urandom_range(0, 65535));
          cin16 = 1'($urandom_range(0, 1));
          sub16 = 1'($urandom_range(0, 1));
          in_valid16 = 1'b1;
          g = 0;
          @(negedge clk);
          while (!in_ready16 && g < 50) begin @(negedge clk); g++; end
          chk("stream_accept_wait", g < 50, 1);
          @(posedge clk); #1;
        end
        in_valid16 = 1'b0;
      end
      begin
        repeat (10) begin
          repeat (3) @(posedge clk);
          #1 out_ready16 = ~out_ready16;
        end
      end
    join
    out_ready16 = 1'b1;
    g = 0;
    while (q.size() != 0 && g < 50) begin @(posedge clk); #1; g++; end
    @(posedge clk); #1;
    chk("stream_drained", q.size(), 0);
    chk("stream_count", nout - nout0, 8);

    // Reset with three transactions offered; the third edge is a reset.
    in_valid16 = 1'b1; cin16 = 1'b0; sub16 = 1'b0;
    a16 = 16'h0101; b16 = 16'h0202;
    @(posedge clk); #1;
    a16 = 16'h0303;
    @(posedge clk); #1;
    a16 = 16'h0505; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid16 = 1'b0;
    chk("midrst_out_valid", out_valid16, 0);
    chk("midrst_outputs", {cout16, ovf16, sum16}, 0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_stale", out_valid16, 0);
    end
    run16("after_reset", 16'h1234, 16'h1111, 1'b0, 1'b0, {1'b0, 1'b0, 16'h2345});

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
